// File: rtl/ysyx_22050710_wb_queue_stage.sv
// ============================================================================
// ysyx_22050710_wb_queue_stage : in-order WB retire queue with RF back-pressure,
// youngest-match GPR forwarding and CSR busy lookup. Option: WB_QUEUE_DEBUG_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22050710_wb_queue_stage #(
  parameter int WORD_WD         = 64,
  parameter int GPR_ADDR_WD     = 5,
  parameter int CSR_ADDR_WD     = 12,
  parameter int DEPTH_LOG2      = 2,
  parameter int MS_TO_WS_BUS_WD = 2 + GPR_ADDR_WD + CSR_ADDR_WD + 2 * WORD_WD
`ifdef WB_QUEUE_DEBUG_EN
  ,
  parameter int DEBUG_BUS_WD    = 1 + 32 + 64 + 64 + 1 + 64
`endif
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic                       o_ws_allowin,
  input  logic                       i_ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] i_ms_to_ws_bus,
  input  logic                       i_rf_gpr_ready,
  input  logic                       i_rf_csr_ready,
  output logic                       o_gpr_wen,
  output logic [GPR_ADDR_WD-1:0]     o_gpr_waddr,
  output logic [WORD_WD-1:0]         o_gpr_wdata,
  output logic                       o_csr_wen,
  output logic [CSR_ADDR_WD-1:0]     o_csr_waddr,
  output logic [WORD_WD-1:0]         o_csr_wdata,
  input  logic [GPR_ADDR_WD-1:0]     i_ds_rs1,
  input  logic [GPR_ADDR_WD-1:0]     i_ds_rs2,
  input  logic [CSR_ADDR_WD-1:0]     i_ds_csr,
  output logic                       o_rs1_hit,
  output logic [WORD_WD-1:0]         o_rs1_data,
  output logic                       o_rs2_hit,
  output logic [WORD_WD-1:0]         o_rs2_data,
  output logic                       o_csr_busy
`ifdef WB_QUEUE_DEBUG_EN
  ,
  input  logic [DEBUG_BUS_WD-1:0]    i_debug_ms_to_ws_bus,
  output logic [DEBUG_BUS_WD-1:0]    o_debug_ws_to_rf_bus
`endif
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  // Incoming entry fields, MSB first: {gpr_wen, rd, gpr_data, csr_wen, csr, csr_data}
  logic                   w_in_gpr_wen;
  logic [GPR_ADDR_WD-1:0] w_in_rd;
  logic [WORD_WD-1:0]     w_in_gpr_data;
  logic                   w_in_csr_wen;
  logic [CSR_ADDR_WD-1:0] w_in_csr;
  logic [WORD_WD-1:0]     w_in_csr_data;

  assign w_in_gpr_wen  = i_ms_to_ws_bus[MS_TO_WS_BUS_WD-1];
  assign w_in_rd       = i_ms_to_ws_bus[MS_TO_WS_BUS_WD-2 -: GPR_ADDR_WD];
  assign w_in_gpr_data = i_ms_to_ws_bus[2*WORD_WD+CSR_ADDR_WD : WORD_WD+CSR_ADDR_WD+1];
  assign w_in_csr_wen  = i_ms_to_ws_bus[WORD_WD+CSR_ADDR_WD];
  assign w_in_csr      = i_ms_to_ws_bus[WORD_WD+CSR_ADDR_WD-1 : WORD_WD];
  assign w_in_csr_data = i_ms_to_ws_bus[WORD_WD-1:0];

  logic                   ent_gpr_wen_q  [DEPTH];
  logic [GPR_ADDR_WD-1:0] ent_rd_q       [DEPTH];
  logic [WORD_WD-1:0]     ent_gpr_data_q [DEPTH];
  logic                   ent_csr_wen_q  [DEPTH];
  logic [CSR_ADDR_WD-1:0] ent_csr_q      [DEPTH];
  logic [WORD_WD-1:0]     ent_csr_data_q [DEPTH];

  logic [DEPTH_LOG2-1:0]  head_q, head_d;
  logic [DEPTH_LOG2-1:0]  tail_q, tail_d;
  logic [DEPTH_LOG2:0]    count_q, count_d;

  logic w_retire;
  logic w_push;

  assign w_retire = (count_q != '0)
                  & (~ent_gpr_wen_q[head_q] | i_rf_gpr_ready)
                  & (~ent_csr_wen_q[head_q] | i_rf_csr_ready);
  assign o_ws_allowin = (count_q < DEPTH_CNT) | w_retire;
  assign w_push       = i_ms_to_ws_valid & o_ws_allowin;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (w_retire) head_d = head_q + DEPTH_LOG2'(1);
    if (w_push)   tail_d = tail_q + DEPTH_LOG2'(1);
    if (w_push && !w_retire)      count_d = count_q + (DEPTH_LOG2 + 1)'(1);
    else if (!w_push && w_retire) count_d = count_q - (DEPTH_LOG2 + 1)'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is deliberately unreset; validity is tracked purely by count_q.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      ent_gpr_wen_q[tail_q]  <= w_in_gpr_wen & (w_in_rd != '0);
      ent_rd_q[tail_q]       <= w_in_rd;
      ent_gpr_data_q[tail_q] <= w_in_gpr_data;
      ent_csr_wen_q[tail_q]  <= w_in_csr_wen;
      ent_csr_q[tail_q]      <= w_in_csr;
      ent_csr_data_q[tail_q] <= w_in_csr_data;
    end
  end

  assign o_gpr_wen   = w_retire & ent_gpr_wen_q[head_q];
  assign o_gpr_waddr = ent_rd_q[head_q];
  assign o_gpr_wdata = ent_gpr_data_q[head_q];
  assign o_csr_wen   = w_retire & ent_csr_wen_q[head_q];
  assign o_csr_waddr = ent_csr_q[head_q];
  assign o_csr_wdata = ent_csr_data_q[head_q];

  // Walk oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    logic [DEPTH_LOG2-1:0] idx;
    idx        = '0;
    o_rs1_hit  = 1'b0;
    o_rs1_data = '0;
    o_rs2_hit  = 1'b0;
    o_rs2_data = '0;
    o_csr_busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + DEPTH_LOG2'(k);
      if ((DEPTH_LOG2 + 1)'(k) < count_q) begin
        if (ent_gpr_wen_q[idx] && (ent_rd_q[idx] == i_ds_rs1) && (i_ds_rs1 != '0)) begin
          o_rs1_hit  = 1'b1;
          o_rs1_data = ent_gpr_data_q[idx];
        end
        if (ent_gpr_wen_q[idx] && (ent_rd_q[idx] == i_ds_rs2) && (i_ds_rs2 != '0)) begin
          o_rs2_hit  = 1'b1;
          o_rs2_data = ent_gpr_data_q[idx];
        end
        if (ent_csr_wen_q[idx] && (ent_csr_q[idx] == i_ds_csr)) begin
          o_csr_busy = 1'b1;
        end
      end
    end
  end

`ifdef WB_QUEUE_DEBUG_EN
  logic [DEBUG_BUS_WD-1:0] ent_dbg_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (w_push) ent_dbg_q[tail_q] <= i_debug_ms_to_ws_bus;
  end

  // Gating the valid bit with retire gives one difftest commit per instruction.
  assign o_debug_ws_to_rf_bus = {ent_dbg_q[head_q][DEBUG_BUS_WD-1] & w_retire,
                                 ent_dbg_q[head_q][DEBUG_BUS_WD-2:0]};
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050710_wb_queue_stage.sv
// ============================================================================
// tb_ysyx_22050710_wb_queue_stage : self-checking bench with a queue-based model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22050710_wb_queue_stage;

  localparam int WW    = 64;
  localparam int GW    = 5;
  localparam int CW    = 12;
  localparam int DEPTH = 4;
  localparam int BW    = 2 + GW + CW + 2 * WW;
  localparam int DBW   = 1 + 32 + 64 + 64 + 1 + 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           o_ws_allowin;
  logic           i_ms_to_ws_valid = 1'b0;
  logic [BW-1:0]  i_ms_to_ws_bus = '0;
  logic           i_rf_gpr_ready = 1'b0;
  logic           i_rf_csr_ready = 1'b0;
  logic           o_gpr_wen;
  logic [GW-1:0]  o_gpr_waddr;
  logic [WW-1:0]  o_gpr_wdata;
  logic           o_csr_wen;
  logic [CW-1:0]  o_csr_waddr;
  logic [WW-1:0]  o_csr_wdata;
  logic [GW-1:0]  i_ds_rs1 = '0;
  logic [GW-1:0]  i_ds_rs2 = '0;
  logic [CW-1:0]  i_ds_csr = '0;
  logic           o_rs1_hit;
  logic [WW-1:0]  o_rs1_data;
  logic           o_rs2_hit;
  logic [WW-1:0]  o_rs2_data;
  logic           o_csr_busy;
`ifdef WB_QUEUE_DEBUG_EN
  logic [DBW-1:0] i_debug_ms_to_ws_bus = '0;
  logic [DBW-1:0] o_debug_ws_to_rf_bus;
`endif

  ysyx_22050710_wb_queue_stage dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .o_ws_allowin         (o_ws_allowin),
    .i_ms_to_ws_valid     (i_ms_to_ws_valid),
    .i_ms_to_ws_bus       (i_ms_to_ws_bus),
    .i_rf_gpr_ready       (i_rf_gpr_ready),
    .i_rf_csr_ready       (i_rf_csr_ready),
    .o_gpr_wen            (o_gpr_wen),
    .o_gpr_waddr          (o_gpr_waddr),
    .o_gpr_wdata          (o_gpr_wdata),
    .o_csr_wen            (o_csr_wen),
    .o_csr_waddr          (o_csr_waddr),
    .o_csr_wdata          (o_csr_wdata),
    .i_ds_rs1             (i_ds_rs1),
    .i_ds_rs2             (i_ds_rs2),
    .i_ds_csr             (i_ds_csr),
    .o_rs1_hit            (o_rs1_hit),
    .o_rs1_data           (o_rs1_data),
    .o_rs2_hit            (o_rs2_hit),
    .o_rs2_data           (o_rs2_data),
    .o_csr_busy           (o_csr_busy)
`ifdef WB_QUEUE_DEBUG_EN
    ,
    .i_debug_ms_to_ws_bus (i_debug_ms_to_ws_bus),
    .o_debug_ws_to_rf_bus (o_debug_ws_to_rf_bus)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           gw;
    bit [GW-1:0]  rd;
    bit [WW-1:0]  gd;
    bit           cw;
    bit [CW-1:0]  csr;
    bit [WW-1:0]  cd;
    bit [DBW-1:0] dbg;
  } ent_t;

  ent_t mq[$];
  ent_t cur_in;
  bit   cur_v;
  int   n_checks = 0;
  int   n_fail   = 0;

  bit          exp_retire, exp_allow, exp_gwen, exp_cwen;
  bit          exp_rs1_hit, exp_rs2_hit, exp_busy;
  bit [WW-1:0] exp_rs1_data, exp_rs2_data;
  ent_t        exp_head;

  function automatic ent_t mk(bit gw, bit [GW-1:0] rd, bit [WW-1:0] gd,
                              bit cw, bit [CW-1:0] csr, bit [WW-1:0] cd);
    ent_t e;
    e.gw = gw; e.rd = rd; e.gd = gd; e.cw = cw; e.csr = csr; e.cd = cd;
    e.dbg = {1'b1, 97'(0), gd ^ cd, gd};
    return e;
  endfunction

  // Expected outputs from the queue contents and the current stimulus.
  function automatic void model_eval();
    exp_retire = 0; exp_gwen = 0; exp_cwen = 0;
    exp_rs1_hit = 0; exp_rs2_hit = 0; exp_busy = 0;
    exp_rs1_data = '0; exp_rs2_data = '0;
    exp_head = mk(0, 0, 0, 0, 0, 0);
    if (mq.size() > 0) begin
      exp_head   = mq[0];
      exp_retire = (!mq[0].gw || i_rf_gpr_ready) && (!mq[0].cw || i_rf_csr_ready);
      exp_gwen   = exp_retire && mq[0].gw;
      exp_cwen   = exp_retire && mq[0].cw;
    end
    exp_allow = (mq.size() < DEPTH) || exp_retire;
    foreach (mq[i]) begin
      if (mq[i].gw && i_ds_rs1 != 0 && mq[i].rd == i_ds_rs1) begin
        exp_rs1_hit = 1; exp_rs1_data = mq[i].gd;
      end
      if (mq[i].gw && i_ds_rs2 != 0 && mq[i].rd == i_ds_rs2) begin
        exp_rs2_hit = 1; exp_rs2_data = mq[i].gd;
      end
      if (mq[i].cw && mq[i].csr == i_ds_csr) exp_busy = 1;
    end
  endfunction

  task automatic apply(input bit v, input ent_t e, input bit gr, input bit cr);
    @(negedge clk);
    i_ms_to_ws_valid = v;
    i_ms_to_ws_bus   = {e.gw, e.rd, e.gd, e.cw, e.csr, e.cd};
`ifdef WB_QUEUE_DEBUG_EN
    i_debug_ms_to_ws_bus = e.dbg;
`endif
    i_rf_gpr_ready = gr;
    i_rf_csr_ready = cr;
    cur_in = e;
    cur_v  = v;
    #1;
    model_eval();
  endtask

  task automatic commit();
    ent_t n;
    if (exp_retire) void'(mq.pop_front());
    if (cur_v && exp_allow) begin
      n = cur_in;
      if (n.rd == 0) n.gw = 0;
      mq.push_back(n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (o_ws_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin got %0b want 1", o_ws_allowin); end
    n_checks++; if (o_gpr_wen !== 1'b0) begin n_fail++; $display("FAIL reset_gpr_wen got %0b want 0", o_gpr_wen); end
    n_checks++; if (o_csr_wen !== 1'b0) begin n_fail++; $display("FAIL reset_csr_wen got %0b want 0", o_csr_wen); end
    n_checks++; if ({o_rs1_hit, o_rs2_hit, o_csr_busy} !== 3'b000) begin n_fail++; $display("FAIL reset_lookup got %b want 000", {o_rs1_hit, o_rs2_hit, o_csr_busy}); end
    rst = 1'b0;
    mq.delete();
  endtask

  task automatic test_single();
    i_ds_rs1 = 5;
    apply(1, mk(1, 5, 64'h1234, 0, 0, 0), 1, 1);
    n_checks++; if (o_gpr_wen !== 1'b0 || o_rs1_hit !== 1'b0) begin n_fail++; $display("FAIL single_push_cycle got wen=%0b hit=%0b want 0 0", o_gpr_wen, o_rs1_hit); end
    commit();
    apply(0, mk(0, 0, 0, 0, 0, 0), 1, 1);
    n_checks++; if (o_gpr_wen !== 1'b1) begin n_fail++; $display("FAIL single_wen got %0b want 1", o_gpr_wen); end
    n_checks++; if (o_gpr_waddr !== 5'd5 || o_gpr_wdata !== 64'h1234) begin n_fail++; $display("FAIL single_write got %0d/%h want 5/1234", o_gpr_waddr, o_gpr_wdata); end
    n_checks++; if (o_rs1_hit !== 1'b1 || o_rs1_data !== 64'h1234) begin n_fail++; $display("FAIL single_retire_hit got %0b/%h want 1/1234", o_rs1_hit, o_rs1_data); end
    commit();
    apply(0, mk(0, 0, 0, 0, 0, 0), 1, 1);
    n_checks++; if (o_gpr_wen !== 1'b0 || o_rs1_hit !== 1'b0) begin n_fail++; $display("FAIL single_empty got wen=%0b hit=%0b want 0 0", o_gpr_wen, o_rs1_hit); end
    commit();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      apply(1, mk(1, 5'(i + 1), 64'h100 + 64'(i), 0, 0, 0), 0, 1);
      n_checks++; if (o_ws_allowin !== 1'b1) begin n_fail++; $display("FAIL fill_allowin[%0d] got %0b want 1", i, o_ws_allowin); end
      commit();
    end
    apply(1, mk(1, 9, 64'h999, 0, 0, 0), 0, 1);
    n_checks++; if (o_ws_allowin !== 1'b0 || o_gpr_wen !== 1'b0) begin n_fail++; $display("FAIL full_stall got allow=%0b wen=%0b want 0 0", o_ws_allowin, o_gpr_wen); end
    commit();
    for (int i = 0; i < 6; i++) begin
      apply(1, mk(1, 5'(10 + i), 64'h300 + 64'(i), 0, 0, 0), 1, 1);
      n_checks++; if (o_ws_allowin !== 1'b1 || o_gpr_wen !== 1'b1) begin n_fail++; $display("FAIL stream[%0d] got allow=%0b wen=%0b want 1 1", i, o_ws_allowin, o_gpr_wen); end
      n_checks++; if (o_gpr_wdata !== (i < 4 ? 64'h100 + 64'(i) : 64'h300 + 64'(i - 4))) begin n_fail++; $display("FAIL stream_order[%0d] got %h", i, o_gpr_wdata); end
      commit();
    end
    for (int i = 0; i < 4; i++) begin
      apply(0, mk(0, 0, 0, 0, 0, 0), 1, 1);
      n_checks++; if (o_gpr_wdata !== 64'h302 + 64'(i) || o_gpr_wen !== 1'b1) begin n_fail++; $display("FAIL drain[%0d] got %0b/%h want 1/%h", i, o_gpr_wen, o_gpr_wdata, 64'h302 + 64'(i)); end
      commit();
    end
  endtask

  task automatic test_forward();
    i_ds_rs1 = 3;
    i_ds_rs2 = 0;
    apply(1, mk(1, 3, 64'hA, 0, 0, 0), 0, 1); commit();
    apply(1, mk(1, 3, 64'hB, 0, 0, 0), 0, 1);
    n_checks++; if (o_rs1_hit !== 1'b1 || o_rs1_data !== 64'hA) begin n_fail++; $display("FAIL fwd_one got %0b/%h want 1/a", o_rs1_hit, o_rs1_data); end
    commit();
    apply(1, mk(1, 0, 64'hDEAD, 0, 0, 0), 0, 1);
    n_checks++; if (o_rs1_hit !== 1'b1 || o_rs1_data !== 64'hB) begin n_fail++; $display("FAIL fwd_youngest got %0b/%h want 1/b", o_rs1_hit, o_rs1_data); end
    commit();
    apply(0, mk(0, 0, 0, 0, 0, 0), 1, 1);
    n_checks++; if (o_rs2_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_x0 got %0b want 0", o_rs2_hit); end
    n_checks++; if (o_rs1_data !== 64'hB || o_gpr_wdata !== 64'hA) begin n_fail++; $display("FAIL fwd_retiring got fwd=%h wr=%h want b a", o_rs1_data, o_gpr_wdata); end
    commit();
    apply(0, mk(0, 0, 0, 0, 0, 0), 1, 1); commit();
    apply(0, mk(0, 0, 0, 0, 0, 0), 1, 1);
    n_checks++; if (o_gpr_wen !== 1'b0 || o_rs1_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_rd0_retire got wen=%0b hit=%0b want 0 0", o_gpr_wen, o_rs1_hit); end
    commit();
  endtask

  task automatic test_partial_grant();
    i_ds_csr = 12'h341;
    apply(1, mk(1, 7, 64'h77, 1, 12'h341, 64'h5555), 1, 0); commit();
    apply(0, mk(0, 0, 0, 0, 0, 0), 1, 0);
    n_checks++; if (o_gpr_wen !== 1'b0 || o_csr_wen !== 1'b0) begin n_fail++; $display("FAIL partial_hold got %0b%0b want 00", o_gpr_wen, o_csr_wen); end
    n_checks++; if (o_csr_busy !== 1'b1) begin n_fail++; $display("FAIL partial_busy got %0b want 1", o_csr_busy); end
    commit();
    apply(0, mk(0, 0, 0, 0, 0, 0), 1, 1);
    n_checks++; if (o_gpr_wen !== 1'b1 || o_csr_wen !== 1'b1) begin n_fail++; $display("FAIL dual_write got %0b%0b want 11", o_gpr_wen, o_csr_wen); end
    n_checks++; if (o_csr_waddr !== 12'h341 || o_csr_wdata !== 64'h5555 || o_gpr_waddr !== 5'd7) begin n_fail++; $display("FAIL dual_data got %h/%h/%0d", o_csr_waddr, o_csr_wdata, o_gpr_waddr); end
    commit();
    apply(0, mk(0, 0, 0, 0, 0, 0), 1, 1);
    n_checks++; if (o_csr_busy !== 1'b0) begin n_fail++; $display("FAIL busy_clear got %0b want 0", o_csr_busy); end
    commit();
  endtask

  task automatic test_async_reset();
    i_ds_rs1 = 4;
    i_ds_csr = 12'h300;
    for (int i = 0; i < 3; i++) begin
      apply(1, mk(1, 5'(4 + i), 64'h40 + 64'(i), 1, 12'h300, 64'h1), 0, 0); commit();
    end
    apply(0, mk(0, 0, 0, 0, 0, 0), 0, 0);
    n_checks++; if (o_rs1_hit !== 1'b1 || o_csr_busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset got hit=%0b busy=%0b want 1 1", o_rs1_hit, o_csr_busy); end
    commit();
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({o_ws_allowin, o_rs1_hit, o_csr_busy, o_gpr_wen, o_csr_wen} !== 5'b10000) begin n_fail++; $display("FAIL async_reset got %b want 10000", {o_ws_allowin, o_rs1_hit, o_csr_busy, o_gpr_wen, o_csr_wen}); end
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply(0, mk(0, 0, 0, 0, 0, 0), 1, 1);
      n_checks++; if (o_gpr_wen !== 1'b0 || o_csr_wen !== 1'b0) begin n_fail++; $display("FAIL post_reset_strobe[%0d] got %0b%0b want 00", i, o_gpr_wen, o_csr_wen); end
      commit();
    end
  endtask

  task automatic test_random();
    bit [CW-1:0] csrs [3];
    int          n_commit = 0;
    csrs[0] = 12'h341; csrs[1] = 12'h300; csrs[2] = 12'h342;
    for (int c = 0; c < 400; c++) begin
      i_ds_rs1 = 5'($urandom_range(0, 7));
      i_ds_rs2 = 5'($urandom_range(0, 7));
      i_ds_csr = csrs[$urandom_range(0, 2)];
      apply(1'($urandom_range(0, 3) != 0),
            mk(1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom},
               1'($urandom_range(0, 2) == 0), csrs[$urandom_range(0, 2)], {$urandom, $urandom}),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
      n_checks++; if (o_ws_allowin !== exp_allow) begin n_fail++; $display("FAIL rnd_allowin c=%0d got %0b want %0b", c, o_ws_allowin, exp_allow); end
      n_checks++; if (o_gpr_wen !== exp_gwen || o_csr_wen !== exp_cwen) begin n_fail++; $display("FAIL rnd_wen c=%0d got %0b%0b want %0b%0b", c, o_gpr_wen, o_csr_wen, exp_gwen, exp_cwen); end
      if (exp_gwen) begin
        n_checks++; if (o_gpr_waddr !== exp_head.rd || o_gpr_wdata !== exp_head.gd) begin n_fail++; $display("FAIL rnd_gpr_write c=%0d got %0d/%h want %0d/%h", c, o_gpr_waddr, o_gpr_wdata, exp_head.rd, exp_head.gd); end
      end
      if (exp_cwen) begin
        n_checks++; if (o_csr_waddr !== exp_head.csr || o_csr_wdata !== exp_head.cd) begin n_fail++; $display("FAIL rnd_csr_write c=%0d got %h/%h want %h/%h", c, o_csr_waddr, o_csr_wdata, exp_head.csr, exp_head.cd); end
      end
      n_checks++; if ({o_rs1_hit, o_rs2_hit, o_csr_busy} !== {exp_rs1_hit, exp_rs2_hit, exp_busy}) begin n_fail++; $display("FAIL rnd_lookup c=%0d got %b want %b", c, {o_rs1_hit, o_rs2_hit, o_csr_busy}, {exp_rs1_hit, exp_rs2_hit, exp_busy}); end
      if (exp_rs1_hit) begin
        n_checks++; if (o_rs1_data !== exp_rs1_data) begin n_fail++; $display("FAIL rnd_rs1_data c=%0d got %h want %h", c, o_rs1_data, exp_rs1_data); end
      end
      if (exp_rs2_hit) begin
        n_checks++; if (o_rs2_data !== exp_rs2_data) begin n_fail++; $display("FAIL rnd_rs2_data c=%0d got %h want %h", c, o_rs2_data, exp_rs2_data); end
      end
`ifdef WB_QUEUE_DEBUG_EN
      n_checks++; if (o_debug_ws_to_rf_bus[DBW-1] !== exp_retire) begin n_fail++; $display("FAIL rnd_dbg_valid c=%0d got %0b want %0b", c, o_debug_ws_to_rf_bus[DBW-1], exp_retire); end
      if (exp_retire) begin
        n_commit++;
        n_checks++; if (o_debug_ws_to_rf_bus[DBW-2:0] !== exp_head.dbg[DBW-2:0]) begin n_fail++; $display("FAIL rnd_dbg_payload c=%0d", c); end
      end
`endif
      commit();
    end
    if (n_commit < 0) $display("commits %0d", n_commit);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_forward();
    test_partial_grant();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_22050710_wb_queue_stage.md
Name: ysyx_22050710_wb_queue_stage

Overview:
Next-generation write-back stage for the ysyx_22050710 core.
- Replaces the single-slot WB register with a parametrised in-order retire queue between MEM and the register files.
- Register-file write ports can apply back-pressure through per-port ready signals.
- Provides youngest-match GPR forwarding and CSR busy lookup over every queued entry, for ID-stage hazard resolution.

Parameters:
WORD_WD, 64, GPR/CSR data width
GPR_ADDR_WD, 5, GPR index width
CSR_ADDR_WD, 12, CSR index width
DEPTH_LOG2, 2, queue depth = 2**DEPTH_LOG2; legal range 1..4
MS_TO_WS_BUS_WD, 2+GPR_ADDR_WD+CSR_ADDR_WD+2*WORD_WD, packed entry width
DEBUG_BUS_WD, 1+32+64+64+1+64, difftest debug bus width (optional feature only)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
o_ws_allowin  out  1  queue can accept this cycle
i_ms_to_ws_valid  in  1  MEM presents an entry
i_ms_to_ws_bus  in  MS_TO_WS_BUS_WD  {gpr_wen, rd, gpr_data, csr_wen, csr, csr_data}, MSB first
i_rf_gpr_ready  in  1  GPR write port free this cycle
i_rf_csr_ready  in  1  CSR write port free this cycle
o_gpr_wen  out  1  GPR write strobe
o_gpr_waddr  out  GPR_ADDR_WD  GPR write index
o_gpr_wdata  out  WORD_WD  GPR write data
o_csr_wen  out  1  CSR write strobe
o_csr_waddr  out  CSR_ADDR_WD  CSR write index
o_csr_wdata  out  WORD_WD  CSR write data
i_ds_rs1  in  GPR_ADDR_WD  ID lookup index 1
i_ds_rs2  in  GPR_ADDR_WD  ID lookup index 2
i_ds_csr  in  CSR_ADDR_WD  ID CSR lookup index
o_rs1_hit  out  1  rs1 pending in queue
o_rs1_data  out  WORD_WD  youngest pending rs1 value
o_rs2_hit  out  1  rs2 pending in queue
o_rs2_data  out  WORD_WD  youngest pending rs2 value
o_csr_busy  out  1  i_ds_csr pending in queue
i_debug_ms_to_ws_bus  in  DEBUG_BUS_WD  per-entry debug (WB_QUEUE_DEBUG_EN only)
o_debug_ws_to_rf_bus  out  DEBUG_BUS_WD  retiring entry debug (WB_QUEUE_DEBUG_EN only)

Behaviour:
Storage
- Circular buffer of DEPTH entries with head/tail pointers (DEPTH_LOG2 bits) and count (DEPTH_LOG2+1 bits).
- Reset clears pointers and count. Entry payload is not reset.

Push, pop and allowin
- push = i_ms_to_ws_valid & o_ws_allowin. Writes entry at tail; tail increments and wraps modulo DEPTH.
- Entry normalisation on push: gpr_wen with rd==0 is stored as gpr_wen=0 (x0 writes discarded).
- retire = (count!=0) & (!head.gpr_wen | i_rf_gpr_ready) & (!head.csr_wen | i_rf_csr_ready).
- An entry with neither wen set retires unconditionally.
- o_ws_allowin = (count < DEPTH) | retire. Full queue with simultaneous retire accepts a push; count stays DEPTH.
- Count: +1 on push only, -1 on retire only, unchanged when both or neither occur.

Write ports
- o_gpr_wen = retire & head.gpr_wen; o_csr_wen = retire & head.csr_wen.
- Addresses and data are always driven from head.
- Both ports write in the same cycle when the entry has both writes.
- A partial grant (one port ready, the other needed but not ready) holds the entry; neither strobe asserts.

Timing and ordering
- Latency: entry pushed at edge N is at head after N; earliest write strobe in cycle N+1.
- Retire order is strictly in-order.

Lookup (purely combinational over valid entries, including head)
- o_rsX_hit = rsX!=0 and some valid entry has gpr_wen & rd==rsX.
- o_rsX_data comes from the youngest matching entry (closest to tail).
- o_csr_busy = some valid entry has csr_wen & csr==i_ds_csr.
- The head entry still matches in the cycle it retires. The ID stage sees the RF value only after the edge.
- A same-cycle push is not visible to lookup until the next cycle.

Reset values
- o_ws_allowin=1; all wen, hit and busy outputs 0.
- Asynchronous reset mid-operation discards all queued entries; no strobe is issued for them.

Optional Feature:
WB_QUEUE_DEBUG_EN
- Defined: debug ports exist. Each entry stores i_debug_ms_to_ws_bus at push.
- o_debug_ws_to_rf_bus = head debug payload with its valid bit (MSB) ANDed with retire. This yields exactly one difftest commit per retired instruction.
- Undefined: debug ports and debug storage are absent.

Test Plan:
- Reset then single push {gpr_wen=1, rd=5, data=0x1234}, both readies=1 -> o_gpr_wen=1, waddr=5, wdata=0x1234 exactly one cycle later; count returns to 0.
- i_rf_gpr_ready=0, push 4 GPR entries (DEPTH=4) -> o_ws_allowin=0 after the 4th. Raise ready with valid pushes continuing -> push and retire in the same cycle; allowin stays 1; writes appear in push order.
- Queue holds rd=3 data 0xA (older) and rd=3 data 0xB (younger); i_ds_rs1=3 -> o_rs1_hit=1, o_rs1_data=0xB. i_ds_rs2=0 with an rd=0 push -> o_rs2_hit=0, and that entry retires with no o_gpr_wen.
- Entry with gpr_wen and csr_wen (csr=0x341), gpr_ready=1, csr_ready=0 -> no strobes, o_csr_busy=1 for i_ds_csr=0x341. csr_ready=1 -> both strobes in one cycle.
- Assert i_rst asynchronously with 3 entries queued -> outputs return to reset values immediately; no write strobes after deassertion.
- WB_QUEUE_DEBUG_EN defined, 3 instructions with ready stalls -> debug valid asserted exactly 3 times, each coincident with its retire.
